// File: rtl/sys_defs.sv
// Shared processor definitions: memory bus commands, request owners and the
// memory tag space size used by the memory-side blocks.
package sys_defs;

  localparam int XLEN         = 32;
  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_REQ_OWNER;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Owner table for outstanding memory load tags. Each entry holds a valid bit
// and the cache that issued the load. A returning tag is looked up and cleared;
// an accepted load sets its entry. When both hit the same tag in one cycle the
// clear is applied first, so the entry ends valid with the new owner.
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS,
  parameter int TAG_W    = $clog2(NUM_TAGS),
  parameter int CNT_W    = $clog2(NUM_TAGS) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               set_en,
  input  logic [TAG_W-1:0]   set_tag,
  input  MEM_REQ_OWNER       set_owner,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_valid,
  output MEM_REQ_OWNER       lookup_owner,
  output logic [CNT_W-1:0]   count
);

  logic [NUM_TAGS-1:0] valid_q;
  logic [NUM_TAGS-1:0] valid_d;
  logic [NUM_TAGS-1:0] owner_q;
  logic                set_live;
  logic                clr_live;

  // Tag 0 means "no tag": it never sets, never matches.
  assign set_live     = set_en && (set_tag != '0);
  assign lookup_valid = (lookup_tag != '0) && valid_q[lookup_tag];
  assign lookup_owner = MEM_REQ_OWNER'(owner_q[lookup_tag]);
  assign clr_live     = lookup_valid;

  // Next valid vector: clear the returning tag, then set the accepted one.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (clr_live) valid_d[lookup_tag] = 1'b0;
    if (set_live) valid_d[set_tag]    = 1'b1;
    valid_d[0] = 1'b0;
  end

  // Valid bits: cleared on reset so all ownership is discarded.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Owner bits: only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    // NOTE: the owner array is deliberately not reset; the reset valid bits mask any stale content.
    if (set_live) owner_q[set_tag] <= set_owner;
  end

  // Popcount of valid entries, saturating at NUM_TAGS-1.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      count = count + CNT_W'(valid_q[i]);
    end
    if (count > CNT_W'(NUM_TAGS - 1)) count = CNT_W'(NUM_TAGS - 1);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single off-chip memory port shared by icache and dcache.
// Grants one requester per cycle (dcache first), muxes its command to memory,
// routes the acceptance tag back to the winner and returning data tags to the
// cache that issued the load. Optional starvation guard: define
// MEM_ARB_STARVE_GUARD_EN to give icache forced priority after STARVE_LIMIT
// consecutive denied request cycles; otherwise dcache priority is strict.
// The memory tag ports are 4 bits wide, so NUM_TAGS is expected to be 16.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int NUM_TAGS     = NUM_MEM_TAGS
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0]                icache2mem_command,
  input  logic [XLEN-1:0]           icache2mem_addr,
  input  logic [1:0]                dcache2mem_command,
  input  logic [XLEN-1:0]           dcache2mem_addr,
  input  logic [63:0]               dcache2mem_data,
  output logic [1:0]                mem_command,
  output logic [XLEN-1:0]           mem_addr,
  output logic [63:0]               mem_data,
  input  logic [3:0]                mem2proc_response,
  input  logic [63:0]               mem2proc_data,
  input  logic [3:0]                mem2proc_tag,
  output logic [3:0]                mem2icache_response,
  output logic [3:0]                mem2dcache_response,
  output logic [3:0]                mem2icache_tag,
  output logic [3:0]                mem2dcache_tag,
  output logic [63:0]               mem2icache_data,
  output logic [63:0]               mem2dcache_data,
  output logic                      grant_icache,
  output logic                      grant_dcache,
  output logic [$clog2(NUM_TAGS):0] outstanding_loads,
  output logic                      orphan_tag_err
);

  localparam int TAG_W = $clog2(NUM_TAGS);

  logic         ic_req;
  logic         dc_req;
  logic         force_ic;
  logic         accepted;
  logic         load_accept;
  logic         ret_valid;
  logic         hit;
  MEM_REQ_OWNER hit_owner;

  // Requests are masked while in reset so no grant can escape.
  assign ic_req = reset_n && (icache2mem_command == BUS_LOAD);
  assign dc_req = reset_n && ((dcache2mem_command == BUS_LOAD) ||
                              (dcache2mem_command == BUS_STORE));

  assign grant_dcache = dc_req && !(force_ic && ic_req);
  assign grant_icache = ic_req && !grant_dcache;

  // Memory-side mux from the winning requester.
  always_comb begin
    mem_command = BUS_NONE;
    mem_addr    = '0;
    mem_data    = '0;
    if (grant_dcache) begin
      mem_command = dcache2mem_command;
      mem_addr    = dcache2mem_addr;
      mem_data    = dcache2mem_data;
    end else if (grant_icache) begin
      mem_command = BUS_LOAD;
      mem_addr    = icache2mem_addr;
    end
  end

  assign accepted    = (grant_icache || grant_dcache) && (mem2proc_response != '0);
  assign load_accept = accepted && (mem_command == BUS_LOAD);

  assign mem2icache_response = grant_icache ? mem2proc_response : '0;
  assign mem2dcache_response = grant_dcache ? mem2proc_response : '0;

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock        (clock),
    .reset_n      (reset_n),
    .set_en       (load_accept),
    .set_tag      (mem2proc_response[TAG_W-1:0]),
    .set_owner    (grant_dcache ? OWNER_DCACHE : OWNER_ICACHE),
    .lookup_tag   (mem2proc_tag[TAG_W-1:0]),
    .lookup_valid (hit),
    .lookup_owner (hit_owner),
    .count        (outstanding_loads)
  );

  // Returning tags go only to the owning cache; data fans out to both.
  assign ret_valid       = reset_n && (mem2proc_tag != '0);
  assign mem2icache_tag  = (ret_valid && hit && hit_owner == OWNER_ICACHE) ? mem2proc_tag : '0;
  assign mem2dcache_tag  = (ret_valid && hit && hit_owner == OWNER_DCACHE) ? mem2proc_tag : '0;
  assign mem2icache_data = reset_n ? mem2proc_data : '0;
  assign mem2dcache_data = reset_n ? mem2proc_data : '0;

  // Sticky error: a tag came back that nobody is waiting for.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                orphan_tag_err <= 1'b0;
    else if (ret_valid && !hit)  orphan_tag_err <= 1'b1;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_q;
  logic             ic_accept;

  assign ic_accept = grant_icache && (mem2proc_response != '0);
  assign force_ic  = force_q;

  // Count consecutive unserved icache cycles; raise forced priority at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end else begin
      if (!ic_req || ic_accept)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (ic_accept)
        force_q <= 1'b0;
      else if (ic_req && (starve_cnt >= CNT_W'(STARVE_LIMIT - 1)))
        force_q <= 1'b1;
    end
  end
`else
  logic unused_starve_limit;

  assign force_ic            = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, response/tag routing, owner
// table set/clear/overwrite, orphan detection, starvation and async reset.
module tb_mem_bus_arbiter;
  import sys_defs::*;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [XLEN-1:0] IA = 32'h0000_1000;
  localparam logic [XLEN-1:0] DA = 32'h0000_2000;
  localparam logic [63:0]     DD = 64'h1122_3344_5566_7788;
  localparam logic [63:0]     MD = 64'hCAFE_F00D_1234_5678;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      icache2mem_command;
  logic [XLEN-1:0] icache2mem_addr;
  logic [1:0]      dcache2mem_command;
  logic [XLEN-1:0] dcache2mem_addr;
  logic [63:0]     dcache2mem_data;
  logic [1:0]      mem_command;
  logic [XLEN-1:0] mem_addr;
  logic [63:0]     mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [3:0]      mem2icache_response;
  logic [3:0]      mem2dcache_response;
  logic [3:0]      mem2icache_tag;
  logic [3:0]      mem2dcache_tag;
  logic [63:0]     mem2icache_data;
  logic [63:0]     mem2dcache_data;
  logic            grant_icache;
  logic            grant_dcache;
  logic [4:0]      outstanding_loads;
  logic            orphan_tag_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .STARVE_LIMIT (8),
    .NUM_TAGS     (16)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .icache2mem_command  (icache2mem_command),
    .icache2mem_addr     (icache2mem_addr),
    .dcache2mem_command  (dcache2mem_command),
    .dcache2mem_addr     (dcache2mem_addr),
    .dcache2mem_data     (dcache2mem_data),
    .mem_command         (mem_command),
    .mem_addr            (mem_addr),
    .mem_data            (mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag),
    .mem2icache_response (mem2icache_response),
    .mem2dcache_response (mem2dcache_response),
    .mem2icache_tag      (mem2icache_tag),
    .mem2dcache_tag      (mem2dcache_tag),
    .mem2icache_data     (mem2icache_data),
    .mem2dcache_data     (mem2dcache_data),
    .grant_icache        (grant_icache),
    .grant_dcache        (grant_dcache),
    .outstanding_loads   (outstanding_loads),
    .orphan_tag_err      (orphan_tag_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ic_cmd, input logic [XLEN-1:0] ic_a,
                       input logic [1:0] dc_cmd, input logic [XLEN-1:0] dc_a,
                       input logic [63:0] dc_d, input logic [3:0] resp,
                       input logic [3:0] tag);
    icache2mem_command = ic_cmd;
    icache2mem_addr    = ic_a;
    dcache2mem_command = dc_cmd;
    dcache2mem_addr    = dc_a;
    dcache2mem_data    = dc_d;
    mem2proc_response  = resp;
    mem2proc_tag       = tag;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    mem2proc_data = MD;

    // Reset asserted with both caches requesting: everything quiet.
    reset_n = 1'b0;
    drive(BUS_LOAD, IA, BUS_LOAD, DA, DD, 4'd3, 4'd3);
    #2;
    check("rst_grant_i", grant_icache, 0);
    check("rst_grant_d", grant_dcache, 0);
    check("rst_cmd", mem_command, BUS_NONE);
    check("rst_addr", mem_addr, 0);
    check("rst_resp_d", mem2dcache_response, 0);
    check("rst_tag_d", mem2dcache_tag, 0);
    check("rst_data_i", mem2icache_data, 0);
    check("rst_cnt", outstanding_loads, 0);
    check("rst_orphan", orphan_tag_err, 0);
    tick();
    reset_n = 1'b1;

    // Both load, dcache wins, tag 3.
    drive(BUS_LOAD, IA, BUS_LOAD, DA, DD, 4'd3, 4'd0);
    #1;
    check("both_grant_d", grant_dcache, 1);
    check("both_grant_i", grant_icache, 0);
    check("both_cmd", mem_command, BUS_LOAD);
    check("both_addr", mem_addr, DA);
    check("both_data", mem_data, DD);
    check("both_resp_d", mem2dcache_response, 3);
    check("both_resp_i", mem2icache_response, 0);
    tick();
    check("cnt_after_3", outstanding_loads, 1);

    // Icache alone, tag 5.
    drive(BUS_LOAD, IA, BUS_NONE, 0, 0, 4'd5, 4'd0);
    #1;
    check("ic_grant", grant_icache, 1);
    check("ic_addr", mem_addr, IA);
    check("ic_data", mem_data, 0);
    check("ic_resp_i", mem2icache_response, 5);
    check("ic_resp_d", mem2dcache_response, 0);
    tick();
    check("cnt_after_5", outstanding_loads, 2);

    // Tag 3 returns to dcache.
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd3);
    #1;
    check("ret3_tag_d", mem2dcache_tag, 3);
    check("ret3_tag_i", mem2icache_tag, 0);
    check("ret3_data_d", mem2dcache_data, MD);
    check("idle_cmd", mem_command, BUS_NONE);
    tick();
    check("cnt_after_ret3", outstanding_loads, 1);

    // Tag 5 returns to icache.
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd5);
    #1;
    check("ret5_tag_i", mem2icache_tag, 5);
    check("ret5_tag_d", mem2dcache_tag, 0);
    tick();
    check("cnt_after_ret5", outstanding_loads, 0);

    // Store accepted with 7: not recorded; returning 7 is an orphan.
    drive(BUS_NONE, 0, BUS_STORE, DA, DD, 4'd7, 4'd0);
    #1;
    check("st_cmd", mem_command, BUS_STORE);
    check("st_data", mem_data, DD);
    check("st_resp_d", mem2dcache_response, 7);
    tick();
    check("st_cnt", outstanding_loads, 0);
    check("st_no_orphan", orphan_tag_err, 0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd7);
    #1;
    check("orph7_tag_i", mem2icache_tag, 0);
    check("orph7_tag_d", mem2dcache_tag, 0);
    tick();
    check("orph7_flag", orphan_tag_err, 1);

    // Same-cycle return of 4 (icache) and new dcache load accepted as 4.
    drive(BUS_LOAD, IA, BUS_NONE, 0, 0, 4'd4, 4'd0);
    tick();
    check("cnt_ic4", outstanding_loads, 1);
    drive(BUS_NONE, 0, BUS_LOAD, DA, DD, 4'd4, 4'd4);
    #1;
    check("swap4_tag_i", mem2icache_tag, 4);
    check("swap4_tag_d", mem2dcache_tag, 0);
    check("swap4_resp_d", mem2dcache_response, 4);
    tick();
    check("swap4_cnt", outstanding_loads, 1);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd4);
    #1;
    check("swap4_ret_d", mem2dcache_tag, 4);
    check("swap4_ret_i", mem2icache_tag, 0);
    tick();
    check("swap4_cnt0", outstanding_loads, 0);

    // Overwrite an already-valid tag 6: count stays 1, new owner icache.
    drive(BUS_NONE, 0, BUS_LOAD, DA, DD, 4'd6, 4'd0);
    tick();
    drive(BUS_LOAD, IA, BUS_NONE, 0, 0, 4'd6, 4'd0);
    tick();
    check("ovw_cnt", outstanding_loads, 1);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd6);
    #1;
    check("ovw_tag_i", mem2icache_tag, 6);
    check("ovw_tag_d", mem2dcache_tag, 0);
    tick();
    check("ovw_cnt0", outstanding_loads, 0);

    // Rejected icache load: granted, response 0, nothing recorded.
    drive(BUS_LOAD, IA, BUS_NONE, 0, 0, 4'd0, 4'd0);
    #1;
    check("rej_grant_i", grant_icache, 1);
    check("rej_resp_i", mem2icache_response, 0);
    tick();
    check("rej_cnt", outstanding_loads, 0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0);
    tick();

    // Continuous contention: icache wins on cycle 9 only with the guard.
    for (int i = 1; i <= 10; i++) begin
      logic exp_gi;
      exp_gi = GUARD && (i == 9);
      drive(BUS_LOAD, IA, BUS_LOAD, DA, DD, exp_gi ? 4'd9 : 4'd0, 4'd0);
      #1;
      check($sformatf("starve_gi_%0d", i), grant_icache, exp_gi);
      check($sformatf("starve_gd_%0d", i), grant_dcache, !exp_gi);
      tick();
    end
    check("starve_cnt", outstanding_loads, GUARD ? 1 : 0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd9);
    #1;
    check("starve_ret_i", mem2icache_tag, GUARD ? 9 : 0);
    tick();
    check("starve_cnt0", outstanding_loads, 0);

    // Reset mid-operation with three loads outstanding.
    drive(BUS_NONE, 0, BUS_LOAD, DA, DD, 4'd10, 4'd0);
    tick();
    drive(BUS_LOAD, IA, BUS_NONE, 0, 0, 4'd11, 4'd0);
    tick();
    drive(BUS_NONE, 0, BUS_LOAD, DA, DD, 4'd12, 4'd0);
    tick();
    check("mid_cnt3", outstanding_loads, 3);
    drive(BUS_LOAD, IA, BUS_LOAD, DA, DD, 4'd13, 4'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_grant_d", grant_dcache, 0);
    check("mid_grant_i", grant_icache, 0);
    check("mid_cmd", mem_command, BUS_NONE);
    check("mid_addr", mem_addr, 0);
    check("mid_data", mem_data, 0);
    check("mid_resp_d", mem2dcache_response, 0);
    check("mid_cnt", outstanding_loads, 0);
    check("mid_orphan", orphan_tag_err, 0);
    tick();
    reset_n = 1'b1;
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd11);
    #1;
    check("post_tag_i", mem2icache_tag, 0);
    check("post_tag_d", mem2dcache_tag, 0);
    tick();
    check("post_orphan", orphan_tag_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single off-chip memory port between the instruction cache and the data cache, replacing the ad-hoc command-based mux in the processor top level. Each cycle it grants at most one requester and forwards that requester's command, address and store data to memory. It records which requester owns each outstanding load tag, so that returning data tags are delivered only to the cache that issued the load. It sits between `icache`/`ex_stage` (dcache) and the memory bus in the R10K top.

## Interface
- `STARVE_LIMIT`, default 8: consecutive denied icache request cycles before icache gets forced priority.
- `NUM_TAGS`, default 16: size of the memory tag space; tag 0 means "no tag".
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `icache2mem_command` in 2: icache request, `BUS_NONE`/`BUS_LOAD`; `BUS_STORE` from icache is treated as `BUS_NONE`.
- `icache2mem_addr` in `XLEN`: icache request address.
- `dcache2mem_command` in 2: dcache request, `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `dcache2mem_addr` in `XLEN`: dcache request address.
- `dcache2mem_data` in 64: dcache store data.
- `mem_command` out 2: command driven to memory.
- `mem_addr` out `XLEN`: address driven to memory.
- `mem_data` out 64: store data driven to memory.
- `mem2proc_response` in 4: tag the memory accepted this cycle; 0 = rejected.
- `mem2proc_data` in 64: returning data.
- `mem2proc_tag` in 4: tag of the returning data; 0 = none.
- `mem2icache_response`, `mem2dcache_response` out 4 each: acceptance tag, routed to the granted requester only.
- `mem2icache_tag`, `mem2dcache_tag` out 4 each: returning tag, routed by owner.
- `mem2icache_data`, `mem2dcache_data` out 64 each: fan-out of `mem2proc_data`.
- `grant_icache`, `grant_dcache` out 1 each: current-cycle grant, one-hot or zero.
- `outstanding_loads` out `$clog2(NUM_TAGS)+1`: count of valid owner entries.
- `orphan_tag_err` out 1: sticky flag for a returning tag with no owner.

## Operation
- Arbitration is combinational from the current-cycle requests.
- Default priority: dcache over icache.
- When the forced-priority flag is set, icache wins.
- Command, address and data are muxed from the winner. `mem_data` is the dcache data when dcache is granted, otherwise 0.
- With no requester, `mem_command` is `BUS_NONE`; `mem_addr` and `mem_data` are 0.
- Response routing:
  - `mem2proc_response` is copied to the granted requester's response output.
  - The other requester's response output is 0.
  - With no grant, both response outputs are 0.
- Owner table: `NUM_TAGS` entries, each holding a valid bit and a 1-bit owner (0 = icache, 1 = dcache). Entry 0 is never written.
- On an accepted `BUS_LOAD` (nonzero response), the entry at that tag is set valid with the winner as owner.
- Accepted stores are not recorded.
- On a nonzero `mem2proc_tag`:
  - If the entry is valid, the tag goes to its owner's tag output and the entry is cleared. The other requester's tag output is 0.
  - If the entry is invalid, both tag outputs are 0 and `orphan_tag_err` sets.
- Same cycle, same tag returned and newly accepted: the clear happens first, then the set. The entry ends valid with the new owner.
- Accepting a load to a tag that is already valid overwrites the owner; the count is not incremented twice.
- `outstanding_loads` = popcount of the valid bits. It saturates at `NUM_TAGS`-1.
- Starvation counter:
  - Increments each cycle icache requests and is not granted, or is granted but the response is 0.
  - Clears on icache acceptance or on a cycle with no icache request.
  - Reaching `STARVE_LIMIT` sets the forced-priority flag.
  - The flag clears on the next icache acceptance.

## Timing
- Request to memory: zero latency, combinational.
- Response and tag routing: combinational from memory inputs plus registered table state.
- Owner table, counter, flag and error flag update on `posedge clock`.
- On reset assertion (async), all registers clear immediately: valid bits 0, counter 0, flag 0, `orphan_tag_err` 0.
- While reset is asserted, all outputs are 0 / `BUS_NONE`. Grants are suppressed during reset.
- Reset in the middle of operation discards all ownership. Tags that return after reset are orphans.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: the starvation counter and forced-priority flag are built as described.
- Undefined: strict dcache priority; no counter or flag logic; `STARVE_LIMIT` is ignored.

## Structure
- The following belong in the shared `sys_defs` package:
  - `BUS_COMMAND` enum (`BUS_NONE`, `BUS_LOAD`, `BUS_STORE`).
  - `MEM_REQ_OWNER` enum (`OWNER_ICACHE`, `OWNER_DCACHE`).
  - `NUM_MEM_TAGS` constant.
- One sub-module, `mem_tag_owner_table`: the set/clear/lookup table with popcount output. The arbitration and starvation logic stays in the top.

## Test plan
- Both caches issue `BUS_LOAD` and memory responds 3: grant goes to dcache and `mem2dcache_response` = 3. Later `mem2proc_tag`=3 drives `mem2dcache_tag` = 3 and `mem2icache_tag` = 0.
- Icache alone issues a load and memory responds 5: `mem_addr` = icache address, entry 5 owner = icache, `outstanding_loads` = 1. Tag 5 returns to icache and the count goes back to 0.
- Dcache store accepted with response 7: no entry is recorded and `outstanding_loads` is unchanged. A returning tag 7 sets `orphan_tag_err`.
- Guard enabled, `STARVE_LIMIT`=8, dcache requesting continuously: on cycle 9 icache is granted. After icache acceptance, priority returns to dcache.
- Same cycle, tag 4 returns (owner icache) and a dcache load is accepted with response 4: the icache receives tag 4 and the next-cycle entry 4 owner = dcache.
- Assert `reset_n` low mid-operation with 3 loads outstanding: outputs go to 0 immediately and `outstanding_loads` = 0. After release, a returning old tag sets `orphan_tag_err`.
